// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register address width, default datapath width
// and the hard-wired zero register.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DEFAULT_XLEN = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/fwd_select.sv
// Operand resolution for one read port: picks the nearest downstream producer
// of the source register, or falls back to register-file data.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int NUM_FWD = 3
) (
  input  logic [REG_ADDR_W-1:0]         raddr,
  input  logic                          use_src,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_wdata,
  input  logic [NUM_FWD-1:0]            fwd_rdy,
  input  logic [XLEN-1:0]               rf_rdata,
  output logic [XLEN-1:0]               data,
  output logic                          stall
);

  logic found;

  // Lowest index wins; once a hit is found, farther producers are ignored.
  always_comb begin
    data  = rf_rdata;
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!found && use_src && fwd_valid[i] && fwd_we[i] &&
          (fwd_waddr[i*REG_ADDR_W +: REG_ADDR_W] != REG_ZERO) &&
          (fwd_waddr[i*REG_ADDR_W +: REG_ADDR_W] == raddr)) begin
        data  = fwd_wdata[i*XLEN +: XLEN];
        stall = ~fwd_rdy[i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch pipeline stage: one valid/ready register slot, operand
// forwarding with load-use interlock, flush, and a saturating stall counter.
module id_operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN      = DEFAULT_XLEN,
  parameter int NUM_FWD   = 3,
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PAYLOAD_W-1:0]          in_payload,
  input  logic [REG_ADDR_W-1:0]         in_raddr1,
  input  logic [REG_ADDR_W-1:0]         in_raddr2,
  input  logic                          in_use1,
  input  logic                          in_use2,
  output logic [REG_ADDR_W-1:0]         rf_raddr1,
  output logic [REG_ADDR_W-1:0]         rf_raddr2,
  input  logic [XLEN-1:0]               rf_rdata1,
  input  logic [XLEN-1:0]               rf_rdata2,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_wdata,
  input  logic [NUM_FWD-1:0]            fwd_rdy,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PAYLOAD_W-1:0]          out_payload,
  output logic [XLEN-1:0]               out_src1,
  output logic [XLEN-1:0]               out_src2,
  output logic [CNT_W-1:0]              stall_cycles
);

  logic                  valid_q, valid_d;
  logic [PAYLOAD_W-1:0]  payload_q, payload_d;
  logic [REG_ADDR_W-1:0] raddr1_q, raddr1_d;
  logic [REG_ADDR_W-1:0] raddr2_q, raddr2_d;
  logic                  use1_q, use1_d;
  logic                  use2_q, use2_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic stall1, stall2, stall, accept;

  fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_src1 (
    .raddr    (raddr1_q),
    .use_src  (use1_q),
    .fwd_valid(fwd_valid),
    .fwd_we   (fwd_we),
    .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata),
    .fwd_rdy  (fwd_rdy),
    .rf_rdata (rf_rdata1),
    .data     (out_src1),
    .stall    (stall1)
  );

  fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_src2 (
    .raddr    (raddr2_q),
    .use_src  (use2_q),
    .fwd_valid(fwd_valid),
    .fwd_we   (fwd_we),
    .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata),
    .fwd_rdy  (fwd_rdy),
    .rf_rdata (rf_rdata2),
    .data     (out_src2),
    .stall    (stall2)
  );

  assign stall        = stall1 | stall2;
  assign out_valid    = valid_q & ~stall & ~flush;
  assign in_ready     = ~reset & (~valid_q | (out_valid & out_ready));
  assign accept       = in_valid & in_ready & ~flush;
  assign rf_raddr1    = raddr1_q;
  assign rf_raddr2    = raddr2_q;
  assign out_payload  = payload_q;
  assign stall_cycles = cnt_q;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    raddr1_d  = raddr1_q;
    raddr2_d  = raddr2_q;
    use1_d    = use1_q;
    use2_d    = use2_q;
    cnt_d     = cnt_q;
    if (reset) begin
      valid_d   = 1'b0;
      payload_d = '0;
      raddr1_d  = '0;
      raddr2_d  = '0;
      use1_d    = 1'b0;
      use2_d    = 1'b0;
      cnt_d     = '0;
    end else begin
      if (flush) begin
        valid_d = 1'b0;
      end else if (accept) begin
        valid_d   = 1'b1;
        payload_d = in_payload;
        raddr1_d  = in_raddr1;
        raddr2_d  = in_raddr2;
        use1_d    = in_use1;
        use2_d    = in_use2;
      end else if (out_valid && out_ready) begin
        valid_d = 1'b0;
      end
      // Only interlock cycles count; EX back-pressure alone does not.
      if (valid_q && stall && !flush && !(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    payload_q <= payload_d;
    raddr1_q  <= raddr1_d;
    raddr2_q  <= raddr2_d;
    use1_q    <= use1_d;
    use2_q    <= use2_d;
    cnt_q     <= cnt_d;
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the stage.
module tb_id_operand_stage;
  localparam int XL = 32;
  localparam int NF = 3;
  localparam int PW = 64;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic [4:0]    in_raddr1, in_raddr2;
  logic          in_use1, in_use2;
  logic [4:0]    rf_raddr1, rf_raddr2;
  logic [XL-1:0] rf_rdata1, rf_rdata2;
  logic [NF-1:0] fwd_valid, fwd_we, fwd_rdy;
  logic [NF*5-1:0]  fwd_waddr;
  logic [NF*XL-1:0] fwd_wdata;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_payload;
  logic [XL-1:0] out_src1, out_src2;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: the instruction held in the stage, plus the counter.
  logic          m_valid;
  logic [PW-1:0] m_payload;
  logic [4:0]    m_ra1, m_ra2;
  logic          m_use1, m_use2;
  int            m_cnt;
  // Expectations for the current cycle.
  logic          e_ov, e_ir, e_stall;
  logic [XL-1:0] e_src1, e_src2;

  id_operand_stage #(.XLEN(XL), .NUM_FWD(NF), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_raddr1(in_raddr1), .in_raddr2(in_raddr2),
    .in_use1(in_use1), .in_use2(in_use2),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata), .fwd_rdy(fwd_rdy),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_payload(out_payload), .out_src1(out_src1), .out_src2(out_src2),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic void resolve(input logic [4:0] ra, input logic u,
                                  input logic [XL-1:0] rf,
                                  output logic [XL-1:0] d, output logic st);
    d = rf;
    st = 1'b0;
    if (!u || ra == 5'd0) return;
    for (int i = 0; i < NF; i++) begin
      if (fwd_valid[i] && fwd_we[i] && fwd_waddr[i*5 +: 5] == ra) begin
        d = fwd_wdata[i*XL +: XL];
        st = !fwd_rdy[i];
        return;
      end
    end
  endfunction

  task automatic eval_model();
    logic s1, s2;
    resolve(m_ra1, m_use1, rf_rdata1, e_src1, s1);
    resolve(m_ra2, m_use2, rf_rdata2, e_src2, s2);
    e_stall = m_valid && (s1 || s2);
    e_ov = m_valid && !e_stall && !flush;
    e_ir = !reset && (!m_valid || (e_ov && out_ready));
  endtask

  // Advance one clock and apply the stage rules to the model.
  task automatic tick();
    logic acc;
    eval_model();
    acc = in_valid && e_ir && !flush;
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_payload = '0; m_cnt = 0;
      m_ra1 = '0; m_ra2 = '0; m_use1 = 1'b0; m_use2 = 1'b0;
    end else begin
      if (e_stall && !flush && m_cnt < (1 << CW) - 1) m_cnt++;
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1; m_payload = in_payload;
        m_ra1 = in_raddr1; m_ra2 = in_raddr2; m_use1 = in_use1; m_use2 = in_use2;
      end else if (e_ov && out_ready) m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_payload = '0; in_raddr1 = 0; in_raddr2 = 0;
    in_use1 = 0; in_use2 = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    fwd_valid = 0; fwd_we = 0; fwd_waddr = 0; fwd_wdata = 0; fwd_rdy = '1;
    flush = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic send(input logic [PW-1:0] p, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2);
    in_valid = 1; in_payload = p; in_raddr1 = r1; in_use1 = u1;
    in_raddr2 = r2; in_use2 = u2;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    #4;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    n_checks++; if (stall_cycles !== '0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", stall_cycles); end
    reset = 0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got %0b exp 1", in_ready); end
    n_checks++; if (out_payload !== '0) begin n_fail++; $display("FAIL rst_payload got %h exp 0", out_payload); end
    @(posedge clk); #1;
  endtask

  task automatic test_no_hazard();
    idle_inputs();
    rf_rdata1 = 32'h11;
    send(64'h100, 5'd3, 1, 5'd4, 1);
    tick();
    in_valid = 0;
    #4;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nohaz_valid got %0b exp 1", out_valid); end
    n_checks++; if (out_src1 !== 32'h11) begin n_fail++; $display("FAIL nohaz_src1 got %h exp 11", out_src1); end
    n_checks++; if (rf_raddr1 !== 5'd3) begin n_fail++; $display("FAIL nohaz_raddr1 got %0d exp 3", rf_raddr1); end
    tick();
    // Back-to-back stream: one acceptance and one departure per cycle.
    for (int k = 0; k < 5; k++) begin
      send(64'h200 + 64'(k), 5'(k + 1), 1, 5'(k + 2), 1);
      rf_rdata1 = 32'h50 + 32'(k);
      #4; eval_model();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %0b exp 1", k, in_ready); end
      if (k > 0) begin
        n_checks++; if (out_payload !== 64'h200 + 64'(k - 1) || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_out[%0d] got v=%0b p=%h exp v=1 p=%h", k, out_valid, out_payload, 64'h200 + 64'(k - 1));
        end
      end
      tick();
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_priority();
    idle_inputs();
    send(64'h300, 5'd1, 0, 5'd5, 1);
    tick();
    in_valid = 0; out_ready = 0;
    fwd_valid = 3'b101; fwd_we = 3'b111; fwd_rdy = 3'b111;
    fwd_waddr = {5'd5, 5'd9, 5'd5};
    fwd_wdata = {32'hC, 32'hB, 32'hA};
    rf_rdata2 = 32'hDEAD;
    #4;
    n_checks++; if (out_src2 !== 32'hA) begin n_fail++; $display("FAIL prio_near got %h exp A", out_src2); end
    tick();
    fwd_valid = 3'b100;
    #4;
    n_checks++; if (out_src2 !== 32'hC) begin n_fail++; $display("FAIL prio_far got %h exp C", out_src2); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL prio_valid got %0b exp 1", out_valid); end
    out_ready = 1;
    tick();
  endtask

  task automatic stall_run(input int n, input string tag);
    idle_inputs();
    send(64'h700, 5'd7, 1, 5'd0, 0);
    tick();
    in_valid = 1; in_payload = 64'h701;
    fwd_valid = 3'b001; fwd_we = 3'b001; fwd_waddr = {10'd0, 5'd7};
    fwd_wdata = {64'd0, 32'h77}; fwd_rdy = 3'b000;
    for (int k = 0; k < n; k++) begin
      #4;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s_stall[%0d] got ov=%0b ir=%0b exp 0/0", tag, k, out_valid, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    stall_run(2, "lu");
    in_valid = 0;
    fwd_rdy = 3'b001;
    #4;
    n_checks++; if (stall_cycles !== 2'd2) begin n_fail++; $display("FAIL lu_cnt got %0d exp 2", stall_cycles); end
    n_checks++; if (out_valid !== 1'b1 || out_src1 !== 32'h77) begin
      n_fail++; $display("FAIL lu_release got ov=%0b src1=%h exp 1/77", out_valid, out_src1);
    end
    tick();
  endtask

  task automatic test_r0_unused();
    idle_inputs();
    rf_rdata1 = 32'h1234;
    fwd_valid = 3'b001; fwd_we = 3'b001; fwd_rdy = 3'b000;
    fwd_waddr = {10'd0, 5'd0}; fwd_wdata = {64'd0, 32'h99};
    send(64'h800, 5'd0, 1, 5'd0, 1);
    tick();
    in_valid = 0;
    #4;
    n_checks++; if (out_valid !== 1'b1 || out_src1 !== 32'h1234) begin
      n_fail++; $display("FAIL r0 got ov=%0b src1=%h exp 1/1234", out_valid, out_src1);
    end
    tick();
    fwd_waddr = {10'd0, 5'd7};
    send(64'h801, 5'd7, 0, 5'd0, 0);
    tick();
    in_valid = 0;
    #4;
    n_checks++; if (out_valid !== 1'b1 || out_src1 !== 32'h1234) begin
      n_fail++; $display("FAIL unused got ov=%0b src1=%h exp 1/1234", out_valid, out_src1);
    end
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    send(64'h900, 5'd2, 1, 5'd3, 1);
    tick();
    send(64'h901, 5'd2, 1, 5'd3, 1);
    flush = 1;
    #4;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ov got %0b exp 0", out_valid); end
    tick();
    flush = 0; in_valid = 0;
    #4;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got %0b exp 0", out_valid); end
    tick();
    // Flush in the middle of an interlock.
    stall_run(1, "fl");
    flush = 1; in_valid = 0;
    tick();
    flush = 0; fwd_rdy = '1;
    #4;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %0b exp 0", out_valid); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    stall_run(5, "sat");
    #4;
    n_checks++; if (stall_cycles !== 2'd3) begin n_fail++; $display("FAIL sat_cnt got %0d exp 3", stall_cycles); end
    reset = 1;
    tick();
    reset = 0;
    #4;
    n_checks++; if (stall_cycles !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL sat_reset got cnt=%0d ov=%0b exp 0/0", stall_cycles, out_valid);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      in_valid = $urandom_range(0, 1);
      in_payload = {$urandom, $urandom};
      in_raddr1 = 5'($urandom_range(0, 7)); in_raddr2 = 5'($urandom_range(0, 7));
      in_use1 = $urandom_range(0, 3) != 0; in_use2 = $urandom_range(0, 3) != 0;
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      for (int i = 0; i < NF; i++) begin
        fwd_valid[i] = $urandom_range(0, 1);
        fwd_we[i] = $urandom_range(0, 3) != 0;
        fwd_rdy[i] = $urandom_range(0, 3) != 0;
        fwd_waddr[i*5 +: 5] = 5'($urandom_range(0, 7));
        fwd_wdata[i*XL +: XL] = $urandom;
      end
      flush = ($urandom_range(0, 15) == 0);
      out_ready = $urandom_range(0, 3) != 0;
      #4; eval_model();
      n_checks++; if (out_valid !== e_ov) begin n_fail++; $display("FAIL rnd_ov[%0d] got %0b exp %0b", c, out_valid, e_ov); end
      n_checks++; if (in_ready !== e_ir) begin n_fail++; $display("FAIL rnd_ir[%0d] got %0b exp %0b", c, in_ready, e_ir); end
      n_checks++; if (int'(stall_cycles) != m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", c, stall_cycles, m_cnt); end
      if (m_valid) begin
        n_checks++; if (out_src1 !== e_src1 || out_src2 !== e_src2) begin
          n_fail++; $display("FAIL rnd_src[%0d] got %h/%h exp %h/%h", c, out_src1, out_src2, e_src1, e_src2);
        end
        n_checks++; if (out_payload !== m_payload || rf_raddr1 !== m_ra1 || rf_raddr2 !== m_ra2) begin
          n_fail++; $display("FAIL rnd_hold[%0d] got p=%h a=%0d/%0d exp p=%h a=%0d/%0d", c, out_payload, rf_raddr1, rf_raddr2, m_payload, m_ra1, m_ra2);
        end
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    m_valid = 0; m_payload = '0; m_cnt = 0;
    m_ra1 = 0; m_ra2 = 0; m_use1 = 0; m_use2 = 0;
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    test_reset();
    test_no_hazard();
    test_priority();
    test_load_use();
    test_r0_unused();
    test_flush();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
